// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared state encodings, board constants and helpers for the
//            rally game.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int LED_W           = 16;
    localparam int WIN_SCORE_DEF   = 5;
    localparam int POINT_TICKS_DEF = 4;

    localparam logic [3:0] POS_L     = 4'd15;
    localparam logic [3:0] POS_R     = 4'd0;
    localparam logic [3:0] SCORE_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_MOVE  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    function automatic logic [LED_W-1:0] ball_led(input logic [3:0] pos);
        return LED_W'(1) << pos;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Brief    : Two-flop synchronizer followed by a registered rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Registered pulse puts the edge three clocks after the raw input rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/rally_controller.sv
`default_nettype none
// ============================================================================
// Module   : rally_controller
// Brief    : One-dimensional two-player rally game on a 16-LED strip.
// Revision : 1.0 - initial release
// ============================================================================
module rally_controller
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int POINT_TICKS = POINT_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sw0,
    input  logic             sw15,
    output logic [LED_W-1:0] led,
    output logic [3:0]       score_l,
    output logic [3:0]       score_r,
    output logic             game_over,
    output logic             winner
);

    localparam int             CNT_W    = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POINT_TICKS - 1);

    logic edge_l;
    logic edge_r;

    edge_sync u_sync_l (
        .clk     (clk),
        .rst     (rst),
        .sw_i    (sw15),
        .pulse_o (edge_l)
    );

    edge_sync u_sync_r (
        .clk     (clk),
        .rst     (rst),
        .sw_i    (sw0),
        .pulse_o (edge_r)
    );

    state_t           state_q,     state_d;
    logic [3:0]       pos_q,       pos_d;
    logic             dir_q,       dir_d;
    logic             server_l_q,  server_l_d;
    logic             scorer_l_q,  scorer_l_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       score_l_q,   score_l_d;
    logic [3:0]       score_r_q,   score_r_d;
    logic [LED_W-1:0] led_q,       led_d;
    logic             game_over_q, game_over_d;
    logic             winner_q,    winner_d;
    logic             hit_l_q,     hit_l_d;
    logic             hit_r_q,     hit_r_d;

    logic             hit_l;
    logic             hit_r;
    logic [3:0]       scorer_score;

    // An edge landing in the tick cycle itself still counts for this window.
    assign hit_l        = hit_l_q | edge_l;
    assign hit_r        = hit_r_q | edge_r;
    assign scorer_score = scorer_l_q ? score_l_q : score_r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SERVE;
            pos_q       <= POS_L;
            dir_q       <= 1'b0;
            server_l_q  <= 1'b1;
            scorer_l_q  <= 1'b0;
            cnt_q       <= '0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            led_q       <= ball_led(POS_L);
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            hit_l_q     <= 1'b0;
            hit_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            server_l_q  <= server_l_d;
            scorer_l_q  <= scorer_l_d;
            cnt_q       <= cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            led_q       <= led_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            hit_l_q     <= hit_l_d;
            hit_r_q     <= hit_r_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        server_l_d = server_l_q;
        scorer_l_d = scorer_l_q;
        cnt_d      = cnt_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        winner_d   = winner_q;
        hit_l_d    = tick ? 1'b0 : hit_l;
        hit_r_d    = tick ? 1'b0 : hit_r;

        case (state_q)
            ST_SERVE: begin
                if (tick && (server_l_q ? hit_l : hit_r)) begin
                    pos_d   = server_l_q ? (POS_L - 4'd1) : (POS_R + 4'd1);
                    dir_d   = ~server_l_q;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if (dir_q && (pos_q == POS_L)) begin
                        if (hit_l) begin
                            dir_d = 1'b0;
                            pos_d = POS_L - 4'd1;
                        end else begin
                            score_r_d  = sat_inc(score_r_q);
                            scorer_l_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = ST_POINT;
                        end
                    end else if (!dir_q && (pos_q == POS_R)) begin
                        if (hit_r) begin
                            dir_d = 1'b1;
                            pos_d = POS_R + 4'd1;
                        end else begin
                            score_l_d  = sat_inc(score_l_q);
                            scorer_l_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = ST_POINT;
                        end
                    end else begin
                        pos_d = dir_q ? (pos_q + 4'd1) : (pos_q - 4'd1);
                    end
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (scorer_score == 4'(WIN_SCORE)) begin
                            winner_d = scorer_l_q;
                            state_d  = ST_OVER;
                        end else begin
                            // The player who conceded serves the next rally.
                            server_l_d = ~scorer_l_q;
                            pos_d      = scorer_l_q ? POS_R : POS_L;
                            dir_d      = scorer_l_q;
                            state_d    = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
        endcase

        // Outputs are computed from next state so they register alongside it.
        case (state_d)
            ST_SERVE, ST_MOVE: led_d = ball_led(pos_d);
            ST_POINT:          led_d = scorer_l_d ? 16'hFF00 : 16'h00FF;
            ST_OVER:           led_d = 16'hFFFF;
        endcase
        game_over_d = (state_d == ST_OVER);
    end

    assign led       = led_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_rally_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rally_controller
// Brief    : Scoreboard bench for rally_controller driving ticks, serves,
//            returns, misses, reset and game-over scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rally_controller;

    typedef struct packed {
        logic [15:0] led;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        go;
        logic        win;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        sw0;
    logic        sw15;
    logic [15:0] led;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        game_over;
    logic        winner;

    int n_checks = 0;
    int n_pass   = 0;

    obs_t exp_q[$];

    // Reference game model: 0 serve, 1 move, 2 point, 3 over.
    int m_state;
    int m_pos;
    int m_cnt;
    int m_sl;
    int m_sr;
    bit m_dir;
    bit m_srv_left;
    bit m_scorer_left;
    bit m_win;
    bit m_hit_l;
    bit m_hit_r;

    always #5 clk = ~clk;

    rally_controller #(
        .WIN_SCORE   (5),
        .POINT_TICKS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .sw0       (sw0),
        .sw15      (sw15),
        .led       (led),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over),
        .winner    (winner)
    );

    function automatic obs_t model_out();
        obs_t o;
        case (m_state)
            0, 1:    o.led = 16'h0001 << m_pos;
            2:       o.led = m_scorer_left ? 16'hFF00 : 16'h00FF;
            default: o.led = 16'hFFFF;
        endcase
        o.sl  = 4'(m_sl);
        o.sr  = 4'(m_sr);
        o.go  = (m_state == 3);
        o.win = m_win;
        return o;
    endfunction

    function void model_reset();
        m_state = 0; m_pos = 15; m_cnt = 0; m_sl = 0; m_sr = 0;
        m_dir = 1'b0; m_srv_left = 1'b1; m_scorer_left = 1'b0; m_win = 1'b0;
        m_hit_l = 1'b0; m_hit_r = 1'b0;
    endfunction

    function void model_step();
        case (m_state)
            0: begin
                if (m_srv_left ? m_hit_l : m_hit_r) begin
                    m_pos   = m_srv_left ? 14 : 1;
                    m_dir   = !m_srv_left;
                    m_state = 1;
                end
            end
            1: begin
                if (m_dir && m_pos == 15) begin
                    if (m_hit_l) begin
                        m_dir = 1'b0; m_pos = 14;
                    end else begin
                        m_sr = (m_sr < 9) ? m_sr + 1 : 9;
                        m_scorer_left = 1'b0; m_cnt = 0; m_state = 2;
                    end
                end else if (!m_dir && m_pos == 0) begin
                    if (m_hit_r) begin
                        m_dir = 1'b1; m_pos = 1;
                    end else begin
                        m_sl = (m_sl < 9) ? m_sl + 1 : 9;
                        m_scorer_left = 1'b1; m_cnt = 0; m_state = 2;
                    end
                end else begin
                    m_pos = m_dir ? m_pos + 1 : m_pos - 1;
                end
            end
            2: begin
                m_cnt++;
                if (m_cnt == 4) begin
                    if ((m_scorer_left ? m_sl : m_sr) == 5) begin
                        m_win = m_scorer_left; m_state = 3;
                    end else begin
                        m_srv_left = !m_scorer_left;
                        m_pos      = m_srv_left ? 15 : 0;
                        m_dir      = !m_srv_left;
                        m_state    = 0;
                    end
                end
            end
            default: ;
        endcase
        m_hit_l = 1'b0;
        m_hit_r = 1'b0;
    endfunction

    // One game tick; outputs are compared one clk after the deciding edge.
    task automatic tick_once();
        obs_t e;
        obs_t a;
        model_step();
        exp_q.push_back(model_out());
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        e = exp_q.pop_front();
        a = {led, score_l, score_r, game_over, winner};
        n_checks++;
        if (a !== e) $display("FAIL tick_scoreboard t=%0t actual=%h expected=%h", $time, a, e);
        else n_pass++;
        repeat (9) @(negedge clk);
    endtask

    task automatic press(input bit left);
        if (left) sw15 = 1'b1; else sw0 = 1'b1;
        repeat (3) @(negedge clk);
        sw15 = 1'b0;
        sw0  = 1'b0;
        repeat (4) @(negedge clk);
        if (left) m_hit_l = 1'b1; else m_hit_r = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t a;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        a = {led, score_l, score_r, game_over, winner};
        n_checks++;
        if (a !== e) $display("FAIL reset_values actual=%h expected=%h", a, e);
        else n_pass++;
        n_checks++;
        if (led !== 16'h8000) $display("FAIL reset_led actual=%h expected=8000", led);
        else n_pass++;
    endtask

    task automatic test_serve_travel();
        press(1'b1);
        tick_once();
        n_checks++;
        if (led !== 16'h4000) $display("FAIL serve_first_step actual=%h expected=4000", led);
        else n_pass++;
        repeat (14) tick_once();
        n_checks++;
        if (led !== 16'h0001) $display("FAIL serve_reach_right actual=%h expected=0001", led);
        else n_pass++;
    endtask

    task automatic test_return_and_miss();
        press(1'b0);
        tick_once();
        n_checks++;
        if (led !== 16'h0002 || score_l !== 4'd0 || score_r !== 4'd0)
            $display("FAIL right_return actual=%h/%0d/%0d expected=0002/0/0", led, score_l, score_r);
        else n_pass++;
        repeat (14) tick_once();
        press(1'b1);
        tick_once();
        n_checks++;
        if (led !== 16'h4000) $display("FAIL left_return actual=%h expected=4000", led);
        else n_pass++;
        repeat (9) tick_once();
        n_checks++;
        if (led !== 16'h0020) $display("FAIL ball_at_5 actual=%h expected=0020", led);
        else n_pass++;
        press(1'b0);
        repeat (6) tick_once();
        n_checks++;
        if (led !== 16'hFF00 || score_l !== 4'd1)
            $display("FAIL early_press_miss actual=%h/%0d expected=ff00/1", led, score_l);
        else n_pass++;
        repeat (3) tick_once();
        n_checks++;
        if (led !== 16'hFF00) $display("FAIL point_hold actual=%h expected=ff00", led);
        else n_pass++;
        tick_once();
        n_checks++;
        if (led !== 16'h0001) $display("FAIL right_serves actual=%h expected=0001", led);
        else n_pass++;
    endtask

    task automatic test_serve_rules();
        press(1'b1);
        tick_once();
        n_checks++;
        if (led !== 16'h0001) $display("FAIL nonserver_ignored actual=%h expected=0001", led);
        else n_pass++;
        press(1'b0);
        tick_once();
        repeat (14) tick_once();
        tick_once();
        n_checks++;
        if (led !== 16'h00FF || score_r !== 4'd1)
            $display("FAIL right_scores actual=%h/%0d expected=00ff/1", led, score_r);
        else n_pass++;
        repeat (4) tick_once();
        n_checks++;
        if (led !== 16'h8000) $display("FAIL left_serves actual=%h expected=8000", led);
        else n_pass++;
    endtask

    task automatic test_same_cycle_hit();
        sw15 = 1'b1;
        repeat (3) @(negedge clk);
        m_hit_l = 1'b1;
        tick_once();
        sw15 = 1'b0;
        n_checks++;
        if (led !== 16'h4000) $display("FAIL same_cycle_hit actual=%h expected=4000", led);
        else n_pass++;
        repeat (15) tick_once();
        n_checks++;
        if (score_l !== 4'd2) $display("FAIL score_after_same_cycle actual=%0d expected=2", score_l);
        else n_pass++;
        repeat (4) tick_once();
    endtask

    task automatic test_game_over();
        for (int p = 0; p < 3; p++) begin
            press(1'b0);
            tick_once();
            repeat (14) tick_once();
            press(1'b1);
            tick_once();
            repeat (15) tick_once();
            repeat (4) tick_once();
        end
        n_checks++;
        if (game_over !== 1'b1 || winner !== 1'b1 || led !== 16'hFFFF || score_l !== 4'd5 || score_r !== 4'd1)
            $display("FAIL game_over actual=%b/%b/%h/%0d/%0d expected=1/1/ffff/5/1",
                     game_over, winner, led, score_l, score_r);
        else n_pass++;
        press(1'b0);
        press(1'b1);
        repeat (3) tick_once();
        n_checks++;
        if (game_over !== 1'b1 || led !== 16'hFFFF || winner !== 1'b1)
            $display("FAIL over_held actual=%b/%h/%b expected=1/ffff/1", game_over, led, winner);
        else n_pass++;
    endtask

    task automatic test_reset_with_tick();
        obs_t e;
        obs_t a;
        press(1'b1);
        tick_once();
        repeat (6) tick_once();
        n_checks++;
        if (led !== 16'h0100) $display("FAIL midrally_pos actual=%h expected=0100", led);
        else n_pass++;
        rst  = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        a = {led, score_l, score_r, game_over, winner};
        n_checks++;
        if (a !== e) $display("FAIL reset_over_tick actual=%h expected=%h", a, e);
        else n_pass++;
        repeat (5) @(negedge clk);
        press(1'b1);
        tick_once();
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        sw0  = 1'b0;
        sw15 = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_serve_travel();
        test_return_and_miss();
        test_serve_rules();
        test_same_cycle_hit();
        test_game_over();
        test_reset();
        test_reset_with_tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
